// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: default geometry, opcode encodings
// and the branch-immediate sign extension used by the next-PC selector.
package inst_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 32'd12;
  localparam int unsigned RESET_PC_DEF = 32'd0;
  localparam logic [31:0] NOP_WORD     = 32'd0;

  typedef enum logic [4:0] {
    OP_J   = 5'b00001,
    OP_BNE = 5'b00010,
    OP_JAL = 5'b00011,
    OP_JR  = 5'b00100,
    OP_BLT = 5'b00110,
    OP_BEX = 5'b10110
  } opcode_e;

  function automatic logic [31:0] sext_br_imm(input logic [16:0] imm);
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch <-> memory/decode bundle. The master modport is the fetch stage; the
// slave modport is whatever sits around it (memory plus decode).
interface inst_fetch_if
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic              stall;
  logic              br_taken;
  logic [16:0]       br_imm;
  logic              jp;
  logic [26:0]       jp_target;
  logic              jr;
  logic [31:0]       jr_target;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus1;
  logic              inst_valid;

  modport master (
    output imem_addr, inst_out, pc_out, pc_plus1, inst_valid,
    input  imem_q, stall, br_taken, br_imm, jp, jp_target, jr, jr_target
  );

  modport slave (
    input  imem_addr, inst_out, pc_out, pc_plus1, inst_valid,
    output imem_q, stall, br_taken, br_imm, jp, jp_target, jr, jr_target
  );
endinterface

// File: rtl/inst_fetch_pc_next_sel.sv
// Next-PC selection: redirect qualification, jr > jp > br priority and the
// PC-relative branch adder. Purely combinational.
module pc_next_sel
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] pc_out_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              valid_i,
  input  logic              br_taken_i,
  input  logic [16:0]       br_imm_i,
  input  logic              jp_i,
  input  logic [26:0]       jp_target_i,
  input  logic              jr_i,
  input  logic [31:0]       jr_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              redirect_o
);

  logic [ADDR_W-1:0] br_target;

  // Priority mux; redirect requests from a bubble slot are not real instructions.
  always_comb begin
    br_target  = pc_out_i + ADDR_W'(1) + ADDR_W'(sext_br_imm(br_imm_i));
    redirect_o = valid_i & (jr_i | jp_i | br_taken_i);
    if (valid_i && jr_i) begin
      next_pc_o = ADDR_W'(jr_target_i);
    end else if (valid_i && jp_i) begin
      next_pc_o = ADDR_W'(jp_target_i);
    end else if (valid_i && br_taken_i) begin
      next_pc_o = br_target;
    end else begin
      next_pc_o = pc_i + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle instruction memory, squashes the
// wrong-path word on redirect and holds its output word through stalls.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic         clock,
  input  logic         reset,
  inst_fetch_if.master fif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              valid_q, valid_d;
  logic              hold_q, hold_d;
  logic [31:0]       hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;

  pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
    .pc_out_i    (fetch_pc_q),
    .pc_i        (pc_q),
    .valid_i     (valid_q),
    .br_taken_i  (fif.br_taken),
    .br_imm_i    (fif.br_imm),
    .jp_i        (fif.jp),
    .jp_target_i (fif.jp_target),
    .jr_i        (fif.jr),
    .jr_target_i (fif.jr_target),
    .next_pc_o   (next_pc),
    .redirect_o  (redirect)
  );

  // Next-state: redirect beats stall; a stall latches the live memory word once.
  always_comb begin
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    valid_d     = valid_q;
    hold_d      = hold_q;
    hold_inst_d = hold_inst_q;
    if (redirect) begin
      pc_d       = next_pc;
      fetch_pc_d = pc_q;
      valid_d    = 1'b0;
      hold_d     = 1'b0;
    end else if (fif.stall) begin
      if (!hold_q) begin
        hold_inst_d = fif.imem_q;
        hold_d      = 1'b1;
      end else begin
        hold_inst_d = hold_inst_q;
      end
    end else begin
      pc_d       = next_pc;
      fetch_pc_d = pc_q;
      valid_d    = 1'b1;
      hold_d     = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= ADDR_W'(RESET_PC);
      fetch_pc_q  <= '0;
      valid_q     <= 1'b0;
      hold_q      <= 1'b0;
      hold_inst_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      valid_q     <= valid_d;
      hold_q      <= hold_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Bubbles present a NOP word so decode never sees stale or wrong-path data.
  assign fif.imem_addr  = pc_q;
  assign fif.pc_out     = fetch_pc_q;
  assign fif.pc_plus1   = fetch_pc_q + ADDR_W'(1);
  assign fif.inst_valid = valid_q;
  assign fif.inst_out   = valid_q ? (hold_q ? hold_inst_q : fif.imem_q) : NOP_WORD;

endmodule

// File: tb/tb_inst_fetch.sv
// Vector-table bench for inst_fetch with a queue of expected outputs; memory
// holds mem[i] = i + 0x100 so every expected word follows from its PC.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int AW = 12;
  localparam int NV = 38;

  typedef struct {
    logic        rst, stall, br;
    logic [16:0] imm;
    logic        jp;
    logic [26:0] jpt;
    logic        jr;
    logic [31:0] jrt;
    logic        ev;
    logic [11:0] epc, eaddr;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [11:0] epc, eaddr, eplus1;
    logic [31:0] einst;
  } exp_t;

  logic clock;
  logic reset;
  logic [31:0] mem [0:4095];
  vec_t vecs [NV];
  exp_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_if #(.ADDR_W(AW)) fif ();

  inst_fetch #(.ADDR_W(AW), .RESET_PC(0)) dut (
    .clock (clock),
    .reset (reset),
    .fif   (fif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) fif.imem_q <= mem[fif.imem_addr];

  function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                              input logic [16:0] imm, input logic jp, input logic [26:0] jpt,
                              input logic jr, input logic [31:0] jrt, input logic ev,
                              input logic [11:0] epc, input logic [11:0] eaddr);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.imm = imm; v.jp = jp; v.jpt = jpt;
    v.jr = jr; v.jrt = jrt; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    reset = 1'b0; fif.stall = 1'b0; fif.br_taken = 1'b0; fif.br_imm = 17'd0;
    fif.jp = 1'b0; fif.jp_target = 27'd0; fif.jr = 1'b0; fif.jr_target = 32'd0;
  endtask

  initial begin
    exp_t e;
    exp_t got;
    int cnt;
    int n_st;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h100 + i;
    drive_idle();
    reset = 1'b1;

    //            rst  st  br  imm        jp  jpt           jr  jrt            ev  epc      eaddr
    vecs[0]  = mk(1'b1,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h000,12'h000);
    vecs[1]  = mk(1'b1,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h000,12'h000);
    vecs[2]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h000,12'h001);
    vecs[3]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h001,12'h002);
    vecs[4]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h002,12'h003);
    vecs[5]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h003,12'h004);
    vecs[6]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h004,12'h005);
    vecs[7]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h005,12'h006);
    vecs[8]  = mk(1'b0,1'b0,1'b1,17'h1FFFD,1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h006,12'h003);
    vecs[9]  = mk(1'b0,1'b0,1'b0,17'h0,    1'b1,27'h30,     1'b0,32'h0,        1'b1,12'h003,12'h004);
    vecs[10] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h004,12'h005);
    vecs[11] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h005,12'h006);
    vecs[12] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h006,12'h007);
    vecs[13] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h007,12'h008);
    vecs[14] = mk(1'b0,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h007,12'h008);
    vecs[15] = mk(1'b0,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h007,12'h008);
    vecs[16] = mk(1'b0,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h007,12'h008);
    vecs[17] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h008,12'h009);
    vecs[18] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h009,12'h00A);
    vecs[19] = mk(1'b0,1'b0,1'b1,17'h5,    1'b1,27'h40,     1'b1,32'h20,       1'b0,12'h00A,12'h020);
    vecs[20] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h020,12'h021);
    vecs[21] = mk(1'b0,1'b1,1'b0,17'h0,    1'b1,27'h10,     1'b0,32'h0,        1'b0,12'h021,12'h010);
    vecs[22] = mk(1'b0,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h021,12'h010);
    vecs[23] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h010,12'h011);
    vecs[24] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b1,32'hABCDEFFD, 1'b0,12'h011,12'hFFD);
    vecs[25] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'hFFD,12'hFFE);
    vecs[26] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'hFFE,12'hFFF);
    vecs[27] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'hFFF,12'h000);
    vecs[28] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h000,12'h001);
    vecs[29] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h001,12'h002);
    vecs[30] = mk(1'b0,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h001,12'h002);
    vecs[31] = mk(1'b1,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h000,12'h000);
    vecs[32] = mk(1'b0,1'b1,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h000,12'h000);
    vecs[33] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h000,12'h001);
    vecs[34] = mk(1'b0,1'b0,1'b0,17'h0,    1'b1,27'h7ABC123,1'b0,32'h0,        1'b0,12'h001,12'h123);
    vecs[35] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h123,12'h124);
    vecs[36] = mk(1'b0,1'b0,1'b1,17'h0000A,1'b0,27'h0,      1'b0,32'h0,        1'b0,12'h124,12'h12E);
    vecs[37] = mk(1'b0,1'b0,1'b0,17'h0,    1'b0,27'h0,      1'b0,32'h0,        1'b1,12'h12E,12'h12F);

    for (int i = 0; i < NV; i++) begin
      reset         = vecs[i].rst;
      fif.stall     = vecs[i].stall;
      fif.br_taken  = vecs[i].br;
      fif.br_imm    = vecs[i].imm;
      fif.jp        = vecs[i].jp;
      fif.jp_target = vecs[i].jpt;
      fif.jr        = vecs[i].jr;
      fif.jr_target = vecs[i].jrt;
      e.ev     = vecs[i].ev;
      e.epc    = vecs[i].epc;
      e.eaddr  = vecs[i].eaddr;
      e.eplus1 = vecs[i].epc + 12'd1;
      e.einst  = vecs[i].ev ? (32'h100 + {20'd0, vecs[i].epc}) : 32'd0;
      sb.push_back(e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      check($sformatf("v%0d inst_valid", i), {31'd0, fif.inst_valid}, {31'd0, got.ev});
      check($sformatf("v%0d pc_out", i),     {20'd0, fif.pc_out},     {20'd0, got.epc});
      check($sformatf("v%0d imem_addr", i),  {20'd0, fif.imem_addr},  {20'd0, got.eaddr});
      check($sformatf("v%0d pc_plus1", i),   {20'd0, fif.pc_plus1},   {20'd0, got.eplus1});
      check($sformatf("v%0d inst_out", i),   fif.inst_out,            got.einst);
    end

    // Reset-to-first-valid latency, bounded wait.
    drive_idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst valid", {31'd0, fif.inst_valid}, 32'd0);
    check("rst addr", {20'd0, fif.imem_addr}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    while (cnt < 8) begin
      @(posedge clock);
      #1;
      cnt++;
      if (fif.inst_valid) break;
    end
    check("first valid latency", cnt, 32'd1);
    check("first pc_out", {20'd0, fif.pc_out}, 32'd0);
    check("first inst_out", fif.inst_out, 32'h100);

    // Random-length stall at pc_out=2, then release without a bubble.
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    check("pre-stall pc_out", {20'd0, fif.pc_out}, 32'd2);
    n_st = $urandom_range(2, 6);
    fif.stall = 1'b1;
    for (int k = 0; k < n_st; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("stall%0d pc_out", k), {20'd0, fif.pc_out}, 32'd2);
      check($sformatf("stall%0d inst_out", k), fif.inst_out, 32'h102);
      check($sformatf("stall%0d valid", k), {31'd0, fif.inst_valid}, 32'd1);
    end
    fif.stall = 1'b0;
    @(posedge clock);
    #1;
    check("release pc_out", {20'd0, fif.pc_out}, 32'd3);
    check("release inst_out", fif.inst_out, 32'h103);
    check("release valid", {31'd0, fif.inst_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
